keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the column strobes of the 4x4 player keypad and samples its row lines.
- Debounces one key at a time and produces the key_scan event stream consumed by who_push and is_right (their keypad_in input).
- Transmitting end of the keypad interface: converts the raw matrix into a clean, one-pulse-per-press key code.

Parameters:
- SCAN_DIV, 50000, clock cycles per scan tick; legal minimum 4 (2-flop row sync settle plus margin).
- DEB_TICKS, 4, consecutive matching scan ticks needed to accept a press or a release; legal minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- row_n  input  4  keypad rows, active-low, asynchronous to clk
- col_n  output  4  column strobes, active-low, exactly one low at a time
- key_code  output  4  code of the accepted key = row*4 + col
- key_valid  output  1  one-cycle pulse per accepted press
- key_pressed  output  1  level, high from acceptance until release is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - col_n=4'b1110; key_code=0; key_valid=0; key_pressed=0.
  - tick divider, debounce counter and row synchronisers cleared; state=SCAN.
- row_n passes through a 2-flop synchroniser (row_s). All decisions use row_s.
- Tick: single-cycle strobe when the divider reaches SCAN_DIV-1; the divider then wraps to 0. Period is exactly SCAN_DIV cycles.
- Column index c (0..3) maps to col_n with bit c low. Rotation order is 0,1,2,3,0...
- State SCAN, on tick:
  - If any row_s bit is low: capture c and the lowest-index low row r; count=1; go to DEBOUNCE. The column does not advance.
  - Otherwise advance c by 1, wrapping 3->0.
- State DEBOUNCE (column frozen), on tick:
  - If row_s bit r is still low: count+1.
  - When count reaches DEB_TICKS: key_code=r*4+c, key_valid=1 for exactly the next clock cycle, key_pressed=1, go to HELD.
  - If bit r is high: go to SCAN without advancing the column. Nothing is emitted.
- State HELD (column frozen), on tick:
  - Bit r low: count=0.
  - Bit r high: count+1.
  - When count reaches DEB_TICKS: key_pressed=0, advance c by 1, go to SCAN.
- key_code holds its last accepted value until the next acceptance.
- Latency: press stable from tick T0 gives key_valid high in the cycle after tick T0+(DEB_TICKS-1).
- Holding a key produces one key_valid only. There is no auto-repeat.
- Multiple keys:
  - Within a column, the lowest row index wins.
  - Other columns are ignored until the current key's release is accepted.
  - A different row in the same column going low during HELD is ignored.
- Glitch shorter than DEB_TICKS ticks: no key_valid, and key_pressed is unchanged.
- Reset mid-debounce or mid-hold: immediate return to reset values. No key_valid is emitted afterwards for that press unless it is re-debounced from SCAN.
- Counter widths sized by $clog2 of the parameters. The debounce counter saturates and never wraps.

Test Plan:
- SCAN_DIV=4, DEB_TICKS=3, no key held after reset:
  - col_n cycles 1110->1101->1011->0111->1110, one step every 4 clocks.
  - key_valid and key_pressed stay 0.
- Hold row 2 low while col 1 is active, for 20 ticks:
  - Exactly one key_valid pulse, with key_code=9, in the cycle after the 3rd matching tick.
  - key_pressed=1.
  - col_n frozen at 1101.
- Release that key:
  - key_pressed falls after 3 high ticks.
  - col_n then advances to 1011.
  - No extra key_valid.
- Row 0 low for 2 ticks only (bounce), then high:
  - No key_valid; key_pressed stays 0.
  - Scanning resumes on the same column, then continues.
- Rows 1 and 3 low together on col 0:
  - key_code=4 (row 1 wins), one pulse.
  - Later press of row 0 on col 2 during HELD is ignored until release.
- Assert rst=0 mid-DEBOUNCE (after 2 matching ticks) while the key stays pressed:
  - Outputs reset immediately.
  - After rst=1, the key is re-detected on col 0 pass and key_valid comes only after 3 fresh matching ticks.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates active-low column strobes, synchronises
// the rows, debounces one key at a time and emits one key_valid pulse per press.
module keypad_scanner #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEB_TICKS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [1:0]         col_q, col_d;
  logic [1:0]         row_q, row_d;
  logic [3:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               pressed_q, pressed_d;
  logic [3:0]         sync1_q, rows_q;
  logic               tick;

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) lowest_low = 2'(i);
    end
  endfunction

  assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
  assign cnt_inc = (cnt_q >= CNT_W'(DEB_TICKS)) ? cnt_q : cnt_q + CNT_W'(1);

  // Rows idle high out of reset so the first tick cannot see a phantom press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'hF;
      rows_q  <= 4'hF;
      div_q   <= '0;
    end else begin
      sync1_q <= row_n;
      rows_q  <= sync1_q;
      div_q   <= tick ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    case (state_q)
      SCAN: if (tick) begin
        if (rows_q != 4'hF) begin
          row_d   = lowest_low(rows_q);
          cnt_d   = CNT_W'(1);
          state_d = DEBOUNCE;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      DEBOUNCE: if (tick) begin
        if (!rows_q[row_q]) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DEB_TICKS)) begin
            code_d    = {row_q, col_q};
            valid_d   = 1'b1;
            pressed_d = 1'b1;
            cnt_d     = '0;
            state_d   = HELD;
          end
        end else begin
          state_d = SCAN;
        end
      end
      // Count consecutive released ticks; any low tick restarts the release.
      HELD: if (tick) begin
        if (!rows_q[row_q]) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DEB_TICKS)) begin
            pressed_d = 1'b0;
            col_d     = col_q + 2'd1;
            state_d   = SCAN;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign col_n       = ~(4'b0001 << col_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the
// strobed columns; directed timing scenarios plus randomized press/glitch mix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] keys = 16'h0;   // bit r*4+c = key at row r, column c held down

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int ev_edge[$];
  int ev_code[$];

  keypad_scanner #(.SCAN_DIV(4), .DEB_TICKS(3)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if ((keys[r*4 +: 4] & ~col_n) != 4'h0) row_n[r] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      ev_edge.push_back(cyc - base);
      ev_code.push_back(int'(key_code));
    end
  end

  function automatic int rel();
    return cyc - base;
  endfunction

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic step_to(input int k);
    while (rel() < k) @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base = cyc;
    #1;
  endtask

  task automatic test_scan();
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step_to(k);
      checks++;
      if (col_n !== col_pat((k / 4) % 4)) begin
        errors++;
        $display("FAIL scan_col edge %0d: col_n=%b expected %b", k, col_n, col_pat((k / 4) % 4));
      end
      checks++;
      if ({key_valid, key_pressed} !== 2'b00) begin
        errors++;
        $display("FAIL scan_idle edge %0d: valid/pressed=%b expected 00", k, {key_valid, key_pressed});
      end
    end
  endtask

  task automatic test_hold();
    int n0;
    do_reset();
    n0 = ev_code.size();
    keys = 16'h0200;
    step_to(84);
    checks++;
    if (ev_code.size() - n0 != 1) begin
      errors++;
      $display("FAIL hold_count: %0d pulses expected 1", ev_code.size() - n0);
    end else begin
      checks++;
      if (ev_code[n0] != 9 || ev_edge[n0] != 16) begin
        errors++;
        $display("FAIL hold_pulse: code %0d at edge %0d expected code 9 at edge 16", ev_code[n0], ev_edge[n0]);
      end
    end
    checks++;
    if (key_pressed !== 1'b1 || col_n !== 4'b1101) begin
      errors++;
      $display("FAIL hold_state: pressed=%b col_n=%b expected 1 1101", key_pressed, col_n);
    end
  endtask

  task automatic test_release();
    int n0;
    n0 = ev_code.size();
    keys = 16'h0;
    step_to(95);
    checks++;
    if (key_pressed !== 1'b1) begin
      errors++;
      $display("FAIL release_early: pressed=%b expected 1", key_pressed);
    end
    step_to(96);
    checks++;
    if (key_pressed !== 1'b0 || col_n !== 4'b1011) begin
      errors++;
      $display("FAIL release_done: pressed=%b col_n=%b expected 0 1011", key_pressed, col_n);
    end
    checks++;
    if (ev_code.size() != n0) begin
      errors++;
      $display("FAIL release_extra: %0d extra pulses expected 0", ev_code.size() - n0);
    end
  endtask

  task automatic test_bounce();
    int n0;
    n0 = ev_code.size();
    keys = 16'h0004;
    step_to(104);
    keys = 16'h0;
    step_to(106);
    checks++;
    if (col_n !== 4'b1011) begin
      errors++;
      $display("FAIL bounce_frozen: col_n=%b expected 1011", col_n);
    end
    step_to(110);
    checks++;
    if (col_n !== 4'b1011) begin
      errors++;
      $display("FAIL bounce_same_col: col_n=%b expected 1011", col_n);
    end
    step_to(112);
    checks++;
    if (col_n !== 4'b0111) begin
      errors++;
      $display("FAIL bounce_resume: col_n=%b expected 0111", col_n);
    end
    checks++;
    if (ev_code.size() != n0 || key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL bounce_quiet: pulses=%0d pressed=%b expected 0 0", ev_code.size() - n0, key_pressed);
    end
  endtask

  task automatic test_reset();
    keys = 16'h0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (col_n !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: col_n=%b code=%0d valid=%b pressed=%b expected 1110 0 0 0",
               col_n, key_code, key_valid, key_pressed);
    end
  endtask

  task automatic test_multi();
    int n0;
    do_reset();
    n0 = ev_code.size();
    keys = 16'h1010;
    step_to(20);
    checks++;
    if (ev_code.size() - n0 != 1 || ev_code[n0] != 4 || ev_edge[n0] != 12) begin
      errors++;
      $display("FAIL multi_row_win: pulses=%0d first code/edge=%0d/%0d expected 1 4/12",
               ev_code.size() - n0, (ev_code.size() > n0) ? ev_code[n0] : -1,
               (ev_edge.size() > n0) ? ev_edge[n0] : -1);
    end
    keys = keys | 16'h0005;
    step_to(30);
    keys = keys & ~16'h0001;
    step_to(40);
    checks++;
    if (ev_code.size() - n0 != 1 || col_n !== 4'b1110 || key_pressed !== 1'b1) begin
      errors++;
      $display("FAIL multi_ignore: pulses=%0d col_n=%b pressed=%b expected 1 1110 1",
               ev_code.size() - n0, col_n, key_pressed);
    end
    keys = 16'h0004;
    step_to(51);
    checks++;
    if (key_pressed !== 1'b1) begin
      errors++;
      $display("FAIL multi_rel_early: pressed=%b expected 1", key_pressed);
    end
    step_to(52);
    checks++;
    if (key_pressed !== 1'b0 || col_n !== 4'b1101) begin
      errors++;
      $display("FAIL multi_rel: pressed=%b col_n=%b expected 0 1101", key_pressed, col_n);
    end
    step_to(69);
    checks++;
    if (ev_code.size() - n0 != 2 || ev_code[n0+1] != 2 || ev_edge[n0+1] != 68) begin
      errors++;
      $display("FAIL multi_second: pulses=%0d last code/edge=%0d/%0d expected 2 2/68",
               ev_code.size() - n0, ev_code[ev_code.size()-1], ev_edge[ev_edge.size()-1]);
    end
    keys = 16'h0;
    wait_cyc(24);
  endtask

  task automatic test_reset_mid();
    int n0;
    do_reset();
    keys = 16'h0010;
    step_to(9);
    n0 = ev_code.size();
    rst = 1'b0;
    #1;
    checks++;
    if (col_n !== 4'b1110 || key_code !== 4'd0 || key_valid !== 1'b0 || key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_values: col_n=%b code=%0d valid=%b pressed=%b expected 1110 0 0 0",
               col_n, key_code, key_valid, key_pressed);
    end
    do_reset();
    step_to(11);
    checks++;
    if (ev_code.size() != n0) begin
      errors++;
      $display("FAIL reset_mid_early: %0d pulses before fresh debounce expected 0", ev_code.size() - n0);
    end
    step_to(13);
    checks++;
    if (ev_code.size() - n0 != 1 || ev_code[n0] != 4 || ev_edge[n0] != 12) begin
      errors++;
      $display("FAIL reset_mid_redetect: pulses=%0d code/edge=%0d/%0d expected 1 4/12",
               ev_code.size() - n0, (ev_code.size() > n0) ? ev_code[n0] : -1,
               (ev_edge.size() > n0) ? ev_edge[n0] : -1);
    end
    keys = 16'h0;
    wait_cyc(24);
  endtask

  task automatic test_random();
    int n0, kind, k, c, exp;
    logic [3:0] rm;
    do_reset();
    wait_cyc(8);
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      n0 = ev_code.size();
      if (kind == 2) begin
        k = $urandom_range(0, 15);
        keys = 16'h0;
        keys[k] = 1'b1;
        wait_cyc($urandom_range(1, 8));
        keys = 16'h0;
        wait_cyc(24);
        checks++;
        if (ev_code.size() != n0 || key_pressed !== 1'b0) begin
          errors++;
          $display("FAIL rand_glitch it %0d key %0d: pulses=%0d pressed=%b expected 0 0",
                   it, k, ev_code.size() - n0, key_pressed);
        end
      end else begin
        if (kind == 0) begin
          k = $urandom_range(0, 15);
          keys = 16'h0;
          keys[k] = 1'b1;
          exp = k;
        end else begin
          c = $urandom_range(0, 3);
          rm = 4'($urandom_range(1, 15));
          keys = 16'h0;
          exp = 0;
          for (int r = 3; r >= 0; r--) begin
            if (rm[r]) begin
              keys[r*4 + c] = 1'b1;
              exp = r * 4 + c;
            end
          end
        end
        wait_cyc(40 + $urandom_range(0, 20));
        checks++;
        if (ev_code.size() - n0 != 1 || ev_code[ev_code.size()-1] != exp) begin
          errors++;
          $display("FAIL rand_press it %0d: pulses=%0d last code=%0d expected 1 pulse code %0d",
                   it, ev_code.size() - n0,
                   (ev_code.size() > 0) ? ev_code[ev_code.size()-1] : -1, exp);
        end
        checks++;
        if (key_pressed !== 1'b1) begin
          errors++;
          $display("FAIL rand_held it %0d: pressed=%b expected 1", it, key_pressed);
        end
        keys = 16'h0;
        wait_cyc(20 + $urandom_range(0, 8));
        checks++;
        if (key_pressed !== 1'b0 || ev_code.size() - n0 != 1) begin
          errors++;
          $display("FAIL rand_release it %0d: pressed=%b pulses=%0d expected 0 1",
                   it, key_pressed, ev_code.size() - n0);
        end
      end
    end
  endtask

  initial begin
    test_scan();
    test_hold();
    test_release();
    test_bounce();
    test_reset();
    test_multi();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
